// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite bus types plus the arbiter's master-id width and state type.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } HBURST_Type;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_state;

    // Two masters on the bus, so one bit identifies a master.
    localparam int MASTER_ID_W = 1;

    typedef enum logic [1:0] {
        PARK = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    // Ownership state that corresponds to a granted master id.
    function automatic arb_state_e own_state(input logic [MASTER_ID_W-1:0] id);
        return id[0] ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// Combinational two-way winner selection: round-robin or fixed priority.
module ahb_arb_rr_pick
    import ahb3lite_pkg::*;
(
    input  logic [1:0]             req_i,
    input  logic [MASTER_ID_W-1:0] last_grant_i,
    input  logic                   rr_en_i,
    output logic [MASTER_ID_W-1:0] winner_o
);

    // With both requesting, alternate away from the last winner or favour master 0.
    always_comb begin
        winner_o = '0;
        if (req_i == 2'b11) begin
            winner_o = rr_en_i ? ~last_grant_i : '0;
        end else if (req_i[1]) begin
            winner_o = 1'b1;
        end else begin
            winner_o = 1'b0;
        end
    end

endmodule

// File: rtl/ahb_lite_bus_arbiter.sv
// Two-master AHB-Lite arbiter and bus mux in front of a single slave port.
// Bus handshake: a transfer's address phase is accepted, and its data phase
// completes, on a rising edge where the slave's HREADY is 1; while HREADY is 0
// the owner must hold its outputs and non-owners see HREADY = 0 (stalled).
// Ownership only changes on an edge where HREADY = 1 and the owner shows IDLE,
// so no data phase of the outgoing master is left unaccepted at handover.
module ahb_lite_bus_arbiter
    import ahb3lite_pkg::*;
#(
    parameter logic [MASTER_ID_W-1:0] DEFAULT_MASTER = '0,
    parameter bit                     RR_EN          = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        m0_HBUSREQ,
    input  logic        m1_HBUSREQ,
    input  logic [31:0] m0_HADDR,
    input  logic [31:0] m1_HADDR,
    input  logic        m0_HWRITE,
    input  logic        m1_HWRITE,
    input  logic [2:0]  m0_HSIZE,
    input  logic [2:0]  m1_HSIZE,
    input  HBURST_Type  m0_HBURST,
    input  HBURST_Type  m1_HBURST,
    input  HTRANS_state m0_HTRANS,
    input  HTRANS_state m1_HTRANS,
    input  logic [31:0] m0_HWDATA,
    input  logic [31:0] m1_HWDATA,
    output logic        m0_HGRANT,
    output logic        m1_HGRANT,
    output logic        m0_HREADY,
    output logic        m1_HREADY,
    output HRESP_state  m0_HRESP,
    output HRESP_state  m1_HRESP,
    output logic [31:0] s_HADDR,
    output logic        s_HWRITE,
    output logic [2:0]  s_HSIZE,
    output HBURST_Type  s_HBURST,
    output HTRANS_state s_HTRANS,
    output logic [31:0] s_HWDATA,
    input  logic        HREADY,
    input  HRESP_state  HRESP,
    output logic [MASTER_ID_W-1:0] HMASTER,
    output logic [MASTER_ID_W-1:0] HMASTER_D,
    output arb_state_e  dbg_state_o,
    output logic [MASTER_ID_W-1:0] dbg_last_grant_o
);

    arb_state_e                 state_q, state_d;
    logic [MASTER_ID_W-1:0]     owner_q, owner_d;
    logic [MASTER_ID_W-1:0]     hmaster_d_q, hmaster_d_d;
    logic [MASTER_ID_W-1:0]     last_grant_q, last_grant_d;
    logic [MASTER_ID_W-1:0]     winner;
    logic [1:0]                 req;
    HTRANS_state                owner_htrans;
    logic                       switch_pt;

    assign req          = {m1_HBUSREQ, m0_HBUSREQ};
    assign owner_htrans = owner_q[0] ? m1_HTRANS : m0_HTRANS;
    assign switch_pt    = HREADY && (owner_htrans == IDLE);

    ahb_arb_rr_pick u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .rr_en_i      (RR_EN),
        .winner_o     (winner)
    );

    // Next ownership: re-arbitrate only at a transfer boundary; the data-phase
    // owner follows the address-phase owner whenever the slave accepts.
    // last_grant records every arbitration award so simultaneous requesters
    // alternate even when the award happens to keep the same owner.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        hmaster_d_d  = HREADY ? owner_q : hmaster_d_q;
        if (switch_pt) begin
            if (req == 2'b00) begin
                state_d = PARK;
                owner_d = DEFAULT_MASTER;
            end else begin
                state_d      = own_state(winner);
                owner_d      = winner;
                last_grant_d = winner;
            end
        end
    end

    // Ownership registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= PARK;
            owner_q      <= DEFAULT_MASTER;
            hmaster_d_q  <= DEFAULT_MASTER;
            last_grant_q <= '1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            hmaster_d_q  <= hmaster_d_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Address/control from the address-phase owner, write data from the data-phase owner.
    always_comb begin
        s_HADDR  = owner_q[0] ? m1_HADDR  : m0_HADDR;
        s_HWRITE = owner_q[0] ? m1_HWRITE : m0_HWRITE;
        s_HSIZE  = owner_q[0] ? m1_HSIZE  : m0_HSIZE;
        s_HBURST = owner_q[0] ? m1_HBURST : m0_HBURST;
        s_HTRANS = HRESET ? IDLE : owner_htrans;
        s_HWDATA = hmaster_d_q[0] ? m1_HWDATA : m0_HWDATA;
    end

    // Ready goes to the address owner only; responses go to the data-phase owner.
    always_comb begin
        m0_HREADY = !HRESET && !owner_q[0] && HREADY;
        m1_HREADY = !HRESET &&  owner_q[0] && HREADY;
        m0_HRESP  = (!HRESET && !hmaster_d_q[0]) ? HRESP : OKAY;
        m1_HRESP  = (!HRESET &&  hmaster_d_q[0]) ? HRESP : OKAY;
    end

    assign m0_HGRANT        = !owner_q[0];
    assign m1_HGRANT        = owner_q[0];
    assign HMASTER          = owner_q;
    assign HMASTER_D        = hmaster_d_q;
    assign dbg_state_o      = state_q;
    assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// Bench for ahb_lite_bus_arbiter: two instances (round-robin/default 0 and
// fixed-priority/default 1) share the same master and slave stimulus.
module tb_ahb_lite_bus_arbiter;
    import ahb3lite_pkg::*;

    // ---------------- clock / reset ----------------
    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus signals ----------------
    logic        busreq [2];
    logic [31:0] haddr  [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    HBURST_Type  hburst [2];
    HTRANS_state htrans [2];
    logic [31:0] hwdata [2];
    logic        hready;
    HRESP_state  hresp;

    // ---------------- per-instance outputs ----------------
    logic        o_grant0 [2];
    logic        o_grant1 [2];
    logic        o_rdy0   [2];
    logic        o_rdy1   [2];
    HRESP_state  o_resp0  [2];
    HRESP_state  o_resp1  [2];
    logic [31:0] o_haddr  [2];
    logic        o_hwrite [2];
    logic [2:0]  o_hsize  [2];
    HBURST_Type  o_hburst [2];
    HTRANS_state o_htrans [2];
    logic [31:0] o_hwdata [2];
    logic [0:0]  o_hm     [2];
    logic [0:0]  o_hmd    [2];
    arb_state_e  o_st     [2];
    logic [0:0]  o_last   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_lite_bus_arbiter #(
            .DEFAULT_MASTER (1'(g)),
            .RR_EN          (g == 0)
        ) u_dut (
            .HCLK             (HCLK),
            .HRESET           (HRESET),
            .m0_HBUSREQ       (busreq[0]),
            .m1_HBUSREQ       (busreq[1]),
            .m0_HADDR         (haddr[0]),
            .m1_HADDR         (haddr[1]),
            .m0_HWRITE        (hwrite[0]),
            .m1_HWRITE        (hwrite[1]),
            .m0_HSIZE         (hsize[0]),
            .m1_HSIZE         (hsize[1]),
            .m0_HBURST        (hburst[0]),
            .m1_HBURST        (hburst[1]),
            .m0_HTRANS        (htrans[0]),
            .m1_HTRANS        (htrans[1]),
            .m0_HWDATA        (hwdata[0]),
            .m1_HWDATA        (hwdata[1]),
            .m0_HGRANT        (o_grant0[g]),
            .m1_HGRANT        (o_grant1[g]),
            .m0_HREADY        (o_rdy0[g]),
            .m1_HREADY        (o_rdy1[g]),
            .m0_HRESP         (o_resp0[g]),
            .m1_HRESP         (o_resp1[g]),
            .s_HADDR          (o_haddr[g]),
            .s_HWRITE         (o_hwrite[g]),
            .s_HSIZE          (o_hsize[g]),
            .s_HBURST         (o_hburst[g]),
            .s_HTRANS         (o_htrans[g]),
            .s_HWDATA         (o_hwdata[g]),
            .HREADY           (hready),
            .HRESP            (hresp),
            .HMASTER          (o_hm[g]),
            .HMASTER_D        (o_hmd[g]),
            .dbg_state_o      (o_st[g]),
            .dbg_last_grant_o (o_last[g])
        );
    end

    // ---------------- scoreboard counters / check ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Instance i: default master = i, round-robin only for instance 0.
    int m_owner [2];
    int m_down  [2];
    int m_last  [2];
    bit m_park  [2];

    function automatic int dflt_of(input int i);
        return i;
    endfunction

    function automatic bit rr_of(input int i);
        return (i == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = dflt_of(i);
            m_down[i]  = dflt_of(i);
            m_last[i]  = 1;
            m_park[i]  = 1'b1;
        end
    endtask

    // Apply the bus rules for one rising edge using the inputs present at it.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (HRESET) begin
                m_owner[i] = dflt_of(i);
                m_down[i]  = dflt_of(i);
                m_last[i]  = 1;
                m_park[i]  = 1'b1;
            end else begin
                int old;
                int who[$];
                old = m_owner[i];
                if (hready) m_down[i] = old;
                if (hready && htrans[old] == IDLE) begin
                    for (int m = 0; m < 2; m++) if (busreq[m]) who.push_back(m);
                    if (who.size() == 0) begin
                        m_owner[i] = dflt_of(i);
                        m_park[i]  = 1'b1;
                    end else begin
                        if (who.size() == 2) m_owner[i] = rr_of(i) ? 1 - m_last[i] : 0;
                        else                 m_owner[i] = who[0];
                        m_last[i] = m_owner[i];
                        m_park[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int o;
            int d;
            arb_state_e exp_st;
            o = m_owner[i];
            d = m_down[i];
            exp_st = m_park[i] ? PARK : ((o == 1) ? OWN1 : OWN0);
            check($sformatf("i%0d HMASTER", i),   32'(o_hm[i]),     32'(o));
            check($sformatf("i%0d HMASTER_D", i), 32'(o_hmd[i]),    32'(d));
            check($sformatf("i%0d m0_HGRANT", i), 32'(o_grant0[i]), 32'(o == 0));
            check($sformatf("i%0d m1_HGRANT", i), 32'(o_grant1[i]), 32'(o == 1));
            check($sformatf("i%0d s_HADDR", i),   o_haddr[i],       haddr[o]);
            check($sformatf("i%0d s_HWRITE", i),  32'(o_hwrite[i]), 32'(hwrite[o]));
            check($sformatf("i%0d s_HSIZE", i),   32'(o_hsize[i]),  32'(hsize[o]));
            check($sformatf("i%0d s_HBURST", i),  32'(o_hburst[i]), 32'(hburst[o]));
            check($sformatf("i%0d s_HTRANS", i),  32'(o_htrans[i]),
                  HRESET ? 32'(IDLE) : 32'(htrans[o]));
            check($sformatf("i%0d s_HWDATA", i),  o_hwdata[i],      hwdata[d]);
            check($sformatf("i%0d m0_HREADY", i), 32'(o_rdy0[i]),
                  32'(!HRESET && o == 0 && hready));
            check($sformatf("i%0d m1_HREADY", i), 32'(o_rdy1[i]),
                  32'(!HRESET && o == 1 && hready));
            check($sformatf("i%0d m0_HRESP", i),  32'(o_resp0[i]),
                  (!HRESET && d == 0) ? 32'(hresp) : 32'(OKAY));
            check($sformatf("i%0d m1_HRESP", i),  32'(o_resp1[i]),
                  (!HRESET && d == 1) ? 32'(hresp) : 32'(OKAY));
            check($sformatf("i%0d last_grant", i), 32'(o_last[i]),  32'(m_last[i]));
            check($sformatf("i%0d state", i),     32'(o_st[i]),     32'(exp_st));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1;
        check_all();
        @(posedge HCLK);
        model_edge();
        @(negedge HCLK);
    endtask

    task automatic set_idle();
        for (int m = 0; m < 2; m++) begin
            busreq[m] = 1'b0;
            haddr[m]  = 32'h0;
            hwrite[m] = 1'b0;
            hsize[m]  = 3'd2;
            hburst[m] = SINGLE;
            htrans[m] = IDLE;
            hwdata[m] = 32'h0;
        end
        hready = 1'b1;
        hresp  = OKAY;
    endtask

    task automatic randomize_inputs();
        for (int m = 0; m < 2; m++) begin
            int r;
            busreq[m] = 1'($urandom_range(0, 1));
            haddr[m]  = $urandom;
            hwrite[m] = 1'($urandom_range(0, 1));
            hsize[m]  = 3'($urandom_range(0, 2));
            hburst[m] = HBURST_Type'($urandom_range(0, 7));
            r = $urandom_range(0, 5);
            htrans[m] = (r > 3) ? IDLE : HTRANS_state'(r);
            hwdata[m] = $urandom;
        end
        hready = ($urandom_range(0, 3) != 0);
        hresp  = ($urandom_range(0, 7) == 0) ? ERROR : OKAY;
        HRESET = ($urandom_range(0, 49) == 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        set_idle();
        HRESET = 1'b1;
        model_reset();
        @(posedge HCLK);
        @(negedge HCLK);
        tick();                       // outputs forced while reset is high
        HRESET = 1'b0;
        #1;
        check("rst HMASTER", 32'(o_hm[0]), 32'd0);
        check("rst m0_HGRANT", 32'(o_grant0[0]), 32'd1);
        check("rst s_HTRANS", 32'(o_htrans[0]), 32'(IDLE));
        check("rst last_grant", 32'(o_last[0]), 32'd1);
        tick();

        // m1 requests while m0 parks IDLE: handover on the next edge.
        busreq[1] = 1'b1;
        tick();
        check("req1 HMASTER", 32'(o_hm[0]), 32'd1);
        check("req1 m0_HREADY", 32'(o_rdy0[0]), 32'd0);

        // m0 INCR4 from 0x1000; m1 starts requesting at beat 2.
        busreq[1] = 1'b0;
        busreq[0] = 1'b1;
        tick();
        check("incr4 owner", 32'(o_hm[0]), 32'd0);
        for (int b = 0; b < 4; b++) begin
            htrans[0] = (b == 0) ? NONSEQ : SEQ;
            haddr[0]  = 32'h1000 + 32'(4 * b);
            hburst[0] = INCR4;
            hwrite[0] = 1'b1;
            hwdata[0] = (b == 0) ? 32'h0 : 32'hA000_0000 + 32'(b - 1);
            if (b == 1) busreq[1] = 1'b1;
            if (b == 3) busreq[0] = 1'b0;
            #1;
            check("incr4 s_HADDR", o_haddr[0], 32'h1000 + 32'(4 * b));
            check("incr4 HMASTER", 32'(o_hm[0]), 32'd0);
            tick();
        end
        htrans[0] = IDLE;
        hwdata[0] = 32'hA000_0003;
        #1;
        check("incr4 last HMASTER", 32'(o_hm[0]), 32'd0);
        check("incr4 last HMASTER_D", 32'(o_hmd[0]), 32'd0);
        check("incr4 last s_HWDATA", o_hwdata[0], 32'hA000_0003);
        tick();
        check("incr4 handover", 32'(o_hm[0]), 32'd1);

        // Both request, every cycle a boundary: RR alternates, fixed stays on 0.
        busreq[0] = 1'b1;
        busreq[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr HMASTER", 32'(o_hm[0]), 32'(k % 2));
            check("fixed HMASTER", 32'(o_hm[1]), 32'd0);
        end

        // m1 write of 0xDEADBEEF with 3 slave wait states.
        busreq[0] = 1'b0;
        htrans[1] = NONSEQ;
        hwrite[1] = 1'b1;
        haddr[1]  = 32'h2000;
        tick();
        htrans[1] = IDLE;
        hwdata[1] = 32'hDEAD_BEEF;
        hready    = 1'b0;
        busreq[0] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            #1;
            check("wait m1_HREADY", 32'(o_rdy1[0]), 32'd0);
            check("wait m0_HREADY", 32'(o_rdy0[0]), 32'd0);
            check("wait s_HWDATA", o_hwdata[0], 32'hDEAD_BEEF);
            check("wait HMASTER", 32'(o_hm[0]), 32'd1);
            tick();
        end
        hready = 1'b1;
        tick();
        check("after wait HMASTER", 32'(o_hm[0]), 32'd0);

        // Two-cycle ERROR response to m0.
        htrans[0] = NONSEQ;
        haddr[0]  = 32'h3000;
        hwrite[0] = 1'b0;
        tick();
        htrans[0] = IDLE;
        hresp     = ERROR;
        for (int e = 0; e < 2; e++) begin
            hready = (e == 1);
            #1;
            check("err m0_HRESP", 32'(o_resp0[0]), 32'(ERROR));
            check("err m1_HRESP", 32'(o_resp1[0]), 32'(OKAY));
            check("err HMASTER", 32'(o_hm[0]), 32'd0);
            tick();
        end
        hresp = OKAY;
        check("err handover", 32'(o_hm[0]), 32'd1);

        // Reset during an m1 SEQ beat.
        htrans[1] = SEQ;
        HRESET    = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        check("rst mid HMASTER", 32'(o_hm[0]), 32'd0);
        check("rst mid s_HTRANS", 32'(o_htrans[0]), 32'(IDLE));
        check("rst mid last_grant", 32'(o_last[0]), 32'd1);
        tick();

        // Random traffic against the model.
        repeat (3000) begin
            randomize_inputs();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
